// File: rtl/sm83_bus_responder.sv
// sm83_bus_responder: memory-side responder for the SM83 external bus.
// Serves boot ROM overlay, HRAM and the boot-disable register directly,
// forwards everything else to an external synchronous memory port, and
// owns the tri-state drive of the shared data bus.
module sm83_bus_responder #(
    parameter int          BOOT_SIZE     = 256,
    parameter logic [15:0] HRAM_BASE     = 16'hFF80,
    parameter int          HRAM_DEPTH    = 127,
    parameter logic [15:0] BOOT_DIS_ADDR = 16'hFF50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_cs,
    input  logic        mem_oe,
    input  logic [15:0] addr_bus,
    inout  wire  [7:0]  data_bus,
    output logic [7:0]  boot_addr,
    input  logic [7:0]  boot_data,
    output logic [15:0] ext_addr,
    output logic        ext_en,
    output logic        ext_we,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    output logic        boot_active,
    output logic        rd_valid
);

    localparam int          HW        = $clog2(HRAM_DEPTH);
    localparam logic [16:0] BOOT_END  = 17'(BOOT_SIZE);
    localparam logic [15:0] HRAM_LAST = HRAM_BASE + 16'(HRAM_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD} state_t;
    typedef enum logic [1:0] {REG_BOOT, REG_DIS, REG_HRAM, REG_EXT} region_t;

    // Address decode in priority order; the boot overlay only exists while enabled.
    function automatic region_t decode(input logic [15:0] a, input logic boot_en);
        if (boot_en && ({1'b0, a} < BOOT_END))
            return REG_BOOT;
        if (a == BOOT_DIS_ADDR)
            return REG_DIS;
        if ((a >= HRAM_BASE) && (a <= HRAM_LAST))
            return REG_HRAM;
        return REG_EXT;
    endfunction

    state_t      state, state_nxt;
    region_t     region_now, region_lat;
    logic [15:0] addr_lat;
    logic [7:0]  rdata;
    logic [7:0]  hram [HRAM_DEPTH];
    logic [15:0] cur_off, lat_off;
    logic        wr_cycle;
    logic        drive;
    logic        unused_off;

    assign region_now = decode(addr_bus, boot_active);
    assign cur_off    = addr_bus - HRAM_BASE;
    assign lat_off    = addr_lat - HRAM_BASE;
    assign unused_off = ^{cur_off[15:HW], lat_off[15:HW]};

    // A write takes effect on the single IDLE edge where it is first seen.
    assign wr_cycle   = rst && (state == IDLE) && mem_cs && !mem_oe;

    assign boot_addr  = addr_bus[7:0];
    assign ext_addr   = addr_bus;
    assign ext_en     = mem_cs && (region_now == REG_EXT);
    assign ext_wdata  = data_bus;
    assign data_bus   = drive ? rdata : 8'hzz;
    assign rd_valid   = drive;

    // State register plus address/region latch and boot-disable latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            boot_active <= 1'b1;
            addr_lat    <= 16'h0000;
            region_lat  <= REG_EXT;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && mem_cs) begin
                addr_lat   <= addr_bus;
                region_lat <= region_now;
            end
            if (wr_cycle && (region_now == REG_DIS) && (data_bus != 8'h00))
                boot_active <= 1'b0;
        end
    end

    // Read data capture one cycle after the request, when sync sources are valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 8'h00;
        end else if (state == RD_WAIT) begin
            case (region_lat)
                REG_BOOT: rdata <= boot_data;
                REG_DIS:  rdata <= {7'h7F, ~boot_active};
                REG_HRAM: rdata <= hram[lat_off[HW-1:0]];
                default:  rdata <= ext_rdata;
            endcase
        end
    end

    // HRAM storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_cycle && (region_now == REG_HRAM))
            hram[cur_off[HW-1:0]] <= data_bus;
    end

    // Next-state logic and bus-facing strobes.
    always_comb begin
        state_nxt = state;
        ext_we    = 1'b0;
        drive     = 1'b0;
        case (state)
            IDLE: begin
                ext_we = wr_cycle && (region_now == REG_EXT);
                if (mem_cs)
                    state_nxt = mem_oe ? RD_WAIT : WR_HOLD;
            end
            RD_WAIT: begin
                state_nxt = RD_DRIVE;
            end
            RD_DRIVE: begin
                // Release is immediate on mem_cs/mem_oe drop, never fighting a CPU write.
                drive = mem_cs && mem_oe;
                if (!(mem_cs && mem_oe && (addr_bus == addr_lat)))
                    state_nxt = IDLE;
            end
            WR_HOLD: begin
                if (!mem_cs || (addr_bus != addr_lat))
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/sm83_bus_responder.md
Name: sm83_bus_responder

Overview:
- Memory-side responder for the cpu_top external bus (mem_cs, mem_oe, addr_bus_ext, data_bus_ext).
- Decodes each CPU bus cycle and serves reads from three sources: the boot ROM overlay, internal HRAM, and the boot-disable register. All other addresses go to an external synchronous memory port.
- Owns tri-state drive of the shared data bus and the sticky boot-ROM-disable latch.
- Replaces the ad-hoc bus glue in system-level benches and top levels.

Parameters:
- BOOT_SIZE, 256: boot overlay covers 0x0000..BOOT_SIZE-1 while boot_active.
- HRAM_BASE, 16'hFF80: first HRAM address.
- HRAM_DEPTH, 127: HRAM bytes (0xFF80..0xFFFE).
- BOOT_DIS_ADDR, 16'hFF50: boot-disable register address.

Ports:
- clk in 1: system clock, all state on rising edge.
- rst in 1: reset, asynchronous, active-low.
- mem_cs in 1: CPU bus cycle active.
- mem_oe in 1: 1 = read, 0 = write (qualified by mem_cs).
- addr_bus in 16: CPU address.
- data_bus inout 8: shared data bus; driven only in RD_DRIVE, else high-Z.
- boot_addr out 8: addr_bus[7:0], combinational, to 1-cycle-latency sync boot ROM.
- ext_addr out 16: addr_bus, combinational.
- ext_en out 1: mem_cs & external region, combinational.
- ext_we out 1: one-cycle write strobe to external memory.
- ext_wdata out 8: data_bus, combinational.
- ext_rdata in 8: external sync memory read data, 1-cycle latency.
- boot_active out 1: boot overlay enabled.
- rd_valid out 1: high while responder drives data_bus.

Behaviour:

Decode, priority order:
- BOOT: boot_active and addr < BOOT_SIZE.
- DIS: addr == BOOT_DIS_ADDR.
- HRAM: HRAM_BASE <= addr <= HRAM_BASE+HRAM_DEPTH-1.
- EXT: everything else, including 0xFFFF.

Reset (rst low, async, immediate):
- state=IDLE, boot_active=1, rdata=0, rd_valid=0, data_bus=Z, ext_we=0.
- HRAM is not reset; contents are undefined until written.

FSM states: IDLE, RD_WAIT, RD_DRIVE, WR_HOLD.
- IDLE, mem_cs&mem_oe: latch addr_lat=addr_bus and region; go to RD_WAIT.
- IDLE, mem_cs&!mem_oe: perform the write at this edge, then go to WR_HOLD.
  - HRAM[addr-HRAM_BASE] <= data_bus.
  - DIS with data != 0 clears boot_active, sticky until reset. Data 0x00 is ignored.
  - EXT: ext_we is high for this IDLE cycle only (combinational: IDLE & mem_cs & !mem_oe & EXT).
  - BOOT-region writes are discarded.
- RD_WAIT, one cycle; capture rdata by region, then go to RD_DRIVE:
  - BOOT: boot_data.
  - EXT: ext_rdata.
  - HRAM: array entry.
  - DIS: {7'h7F, ~boot_active}.
- RD_DRIVE: data_bus=rdata, rd_valid=1.
  - Stays while mem_cs&mem_oe&addr_bus==addr_lat.
  - mem_cs low: go to IDLE, release bus the same cycle (drive is gated combinationally by mem_cs&mem_oe).
  - Address change or mem_oe drop with mem_cs high: go to IDLE and re-evaluate next cycle.
- WR_HOLD: no further write effects. Return to IDLE when mem_cs drops or addr_bus changes, so a held write causes exactly one write.

Timing and boundary conditions:
- Read latency: request sampled at edge N; data valid on data_bus after edge N+1. The bench samples at edge N+2.
- Boot ROM and external memory are addressed combinationally in IDLE so they sample at edge N.
- The boot-disable write takes effect after its edge. A read of 0x0000 issued afterwards routes to EXT.
- Never drive data_bus when mem_oe=0 (no contention with a CPU write).

Test Plan:
- Reset/boot read: rst low -> data_bus Z, boot_active=1, rd_valid=0. Release, ROM[0x00]=0x31, read 0x0000 -> data_bus=0x31 at edge N+2, rd_valid=1. Drop mem_cs -> Z same cycle.
- HRAM: write 0xFF80<=0xA5 and 0xFFFE<=0x5A, read back -> 0xA5, 0x5A, ext_we never asserted. Write 0xFF7F and 0xFFFF -> ext_we pulses with ext_wdata=data.
- Boot disable: write 0x00 to 0xFF50 -> boot_active stays 1, read 0xFF50=0xFE. Write 0x01 -> boot_active=0, read 0xFF50=0xFF. Read 0x0000 with ext_rdata=0xC3 -> 0xC3.
- Held write: mem_cs=1, mem_oe=0 at 0xC000 for 5 cycles -> ext_we high exactly 1 cycle. Step addr to 0xC001 while held -> second single pulse.
- Mid-read address change: read 0x0001 (ROM 0xFE), switch to 0xFF80 at edge N+3 -> bus Z next cycle, then HRAM value after two edges.
- Reset mid-read: assert rst during RD_DRIVE after boot disable -> data_bus Z asynchronously, boot_active=1, next read of 0x0000 returns ROM data.
